// File: rtl/ring_phase_tracker_pkg.sv
// ring_phase_tracker_pkg: state encoding, default geometry and rotate-left helper shared by ring consumers
package ring_phase_tracker_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_LOCK_CNT = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCKED = 2'd2} state_t;
  function automatic logic [31:0] rotl(input logic [31:0] v, input int w);
    return ((v << 1) | (v >> (w - 1))) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/ring_phase_tracker_if.sv
// ring_phase_tracker_if: phase sample in, decoded phase/health out; err_count exists with RING_PHASE_ERRCNT_EN
interface ring_phase_tracker_if import ring_phase_tracker_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROT_W = 8
);
  logic [WIDTH-1:0] phase_in;
  logic phase_vld;
  logic [$clog2(WIDTH)-1:0] phase_idx;
  logic [ROT_W-1:0] rot_count;
  logic locked;
  logic err;
`ifdef RING_PHASE_ERRCNT_EN
  logic [7:0] err_count;
  modport master (output phase_in, phase_vld, input phase_idx, rot_count, locked, err, err_count);
  modport slave (input phase_in, phase_vld, output phase_idx, rot_count, locked, err, err_count);
`else
  modport master (output phase_in, phase_vld, input phase_idx, rot_count, locked, err);
  modport slave (input phase_in, phase_vld, output phase_idx, rot_count, locked, err);
`endif
endinterface

// File: rtl/ring_phase_tracker_onehot_decode.sv
// onehot_decode: combinational one-hot legality check and binary index of the set bit
module onehot_decode #(
  parameter int WIDTH = 4,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             is_onehot
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) idx |= vec[i] ? IW'(i) : '0;
  end
  assign is_onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
endmodule

// File: rtl/ring_phase_tracker.sv
// ring_phase_tracker: checks ring-counter phase order, locks, decodes phase, counts rotations; RING_PHASE_ERRCNT_EN adds err_count
module ring_phase_tracker import ring_phase_tracker_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ROT_W = 8
) (
  input logic clk,
  input logic reset,
  ring_phase_tracker_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int SW = $clog2(LOCK_CNT + 1);
  state_t state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [IW-1:0] idx_q, idx_d, dec_idx;
  logic [ROT_W-1:0] rot_q, rot_d;
  logic err_q, err_d, is_oh, is_exp;
  onehot_decode #(.WIDTH(WIDTH)) u_dec (.vec(bus.phase_in), .idx(dec_idx), .is_onehot(is_oh));
  assign is_exp = rotl(32'(ref_q), WIDTH) == 32'(bus.phase_in);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q <= '0;
      ref_q <= '0;
      idx_q <= '0;
      rot_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      ref_q <= ref_d;
      idx_q <= idx_d;
      rot_q <= rot_d;
      err_q <= err_d;
    end
  end
  // IDLE re-seeds on any legal sample, so the hold check only applies once tracking
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    ref_d = ref_q;
    idx_d = idx_q;
    rot_d = rot_q;
    err_d = 1'b0;
    if (bus.phase_vld) begin
      if (!is_oh) begin
        err_d = 1'b1;
        state_d = IDLE;
        step_d = '0;
      end else if (state_q == IDLE || bus.phase_in != ref_q) begin
        ref_d = bus.phase_in;
        idx_d = dec_idx;
        if (state_q == IDLE || !is_exp) begin
          err_d = state_q != IDLE;
          state_d = ACQ;
          step_d = '0;
        end else if (state_q == ACQ) begin
          step_d = step_q + SW'(1);
          state_d = (int'(step_q) + 1 == LOCK_CNT) ? LOCKED : ACQ;
        end else begin
          rot_d = bus.phase_in[0] ? rot_q + ROT_W'(1) : rot_q;
        end
      end
    end
  end
  assign bus.phase_idx = idx_q;
  assign bus.rot_count = rot_q;
  assign bus.locked = state_q == LOCKED;
  assign bus.err = err_q;
`ifdef RING_PHASE_ERRCNT_EN
  logic [7:0] ec_q;
  always_ff @(posedge clk) begin
    if (reset) ec_q <= '0;
    else if (err_d && ec_q != 8'hff) ec_q <= ec_q + 8'd1;
  end
  assign bus.err_count = ec_q;
`endif
endmodule

// File: doc/ring_phase_tracker.md
Name: ring_phase_tracker

Overview:
Downstream consumer of the ring counter's one-hot state vector. Each valid sample is checked for one-hot legality and for correct rotation order. The block locks after a run of correct steps, reports the current phase as a binary index, and counts full rotations. It is the checker/decoder stage that sits between the ring counter and any logic that needs a binary phase or a health flag.

Parameters:
WIDTH, 4, ring length (bits of the one-hot phase vector), >= 2
LOCK_CNT, 3, consecutive correct steps required to enter LOCKED, >= 1
ROT_W, 8, width of the rotation counter

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
phase_in  input  WIDTH  one-hot phase from the ring counter
phase_vld  input  1  phase_in is sampled this cycle
phase_idx  output  $clog2(WIDTH)  binary index of the last accepted legal sample
rot_count  output  ROT_W  completed rotations while LOCKED, wraps modulo 2^ROT_W
locked  output  1  high while the state is LOCKED
err  output  1  one-cycle pulse on an illegal or out-of-order sample

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. All outputs are registered, with 1-cycle latency from the sampling edge.
- Reset values: phase_idx=0, rot_count=0, locked=0, err=0, state=IDLE, step_cnt=0, ref=0.
- Reset has priority over phase_vld. A reset mid-operation returns all state to its reset values at the next edge.
- phase_vld=0: no state change; err=0 on the next cycle.
- Legal sample: exactly one bit of phase_in is set.
- Expected next phase = rotate-left of ref (bit i -> bit i+1, bit WIDTH-1 -> bit 0).
- Hold sample (legal and equal to ref): no state or counter change, err=0. This tolerates a stalled counter.
- State machine, with states IDLE, ACQ and LOCKED:
  - Illegal sample, any state: err=1, state <- IDLE, step_cnt <- 0. ref and phase_idx hold. rot_count holds.
  - IDLE + legal sample: state <- ACQ, step_cnt <- 0, ref <- sample.
  - ACQ + expected sample: step_cnt+1, ref <- sample. When step_cnt+1 == LOCK_CNT, state <- LOCKED.
  - ACQ or LOCKED + legal but unexpected sample (not hold): err=1, state <- ACQ, step_cnt <- 0, ref <- sample.
  - LOCKED + expected sample: ref <- sample. If the sample is bit 0 (wrap from bit WIDTH-1), rot_count+1, wrapping at 2^ROT_W.
- phase_idx updates on every accepted legal sample (including the re-seed on a sequence error). It holds on illegal samples.
- rot_count is cleared only by reset.

Optional Feature:
RING_PHASE_ERRCNT_EN
- Defined: adds output port err_count (8 bits). It increments on every err pulse, saturates at 255, and is cleared only by reset.
- Not defined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package/defs file holds:
  - state encoding: IDLE=2'd0, ACQ=2'd1, LOCKED=2'd2
  - rotate-left helper function
  - default WIDTH/LOCK_CNT
- Natural sub-module: onehot_decode. It is combinational and maps WIDTH bits to an index plus an is_onehot flag; reused by other ring-consuming blocks.

Test Plan:
All scenarios use WIDTH=4 and LOCK_CNT=3.
- Reset 2 cycles, then phase_vld=1 with 0001,0010,0100,1000 -> locked=1 the cycle after 1000 is sampled, phase_idx=3, err never set, rot_count=0.
- From LOCKED feed 0001, then continue through 2 further full cycles -> rot_count=1 after the first 0001, reaches 3; phase_idx follows 0,1,2,3.
- LOCKED, feed 0011 -> err=1 for exactly one cycle, locked=0, phase_idx holds; then 0000 -> err again; then 0010 -> IDLE->ACQ, err=0.
- LOCKED at 0001, feed 0100 -> err pulse, locked=0, phase_idx=2; then 1000,0001,0010 -> locked=1 again.
- LOCKED, repeat 0010 for 3 cycles, then phase_vld=0 for 4 cycles, then 0100 -> no err, locked stays 1.
- LOCKED with rot_count=5 and phase_vld=1, assert reset 1 cycle -> next cycle all outputs 0, state IDLE. With RING_PHASE_ERRCNT_EN, 300 forced illegal samples -> err_count=255.
